// File: rtl/lfu_pkg.sv
// Shared types for the LFU counter bank: way index, counter word, aging FSM state.
package lfu_pkg;

  localparam int WAYS         = 4;
  localparam int SIZE_COUNTER = 4;

  typedef logic [1:0]              way_t;
  typedef logic [SIZE_COUNTER-1:0] cnt_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } age_state_e;

endpackage

// File: rtl/lfu_age_ctrl.sv
// Aging controller: counts accepted accesses and, every AGE_PERIOD of them,
// walks all sets once so the bank can halve their counters.
module lfu_age_ctrl
  import lfu_pkg::*;
#(
  parameter int NUM_SETS   = 16,
  parameter int AGE_PERIOD = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        access_valid,
  output logic                        access_ready,
  output logic                        access_accept,
  output logic                        halve_en,
  output logic [$clog2(NUM_SETS)-1:0] halve_set
);

  localparam int SW = $clog2(NUM_SETS);
  localparam int TW = $clog2(AGE_PERIOD + 1);

  age_state_e    state, state_nxt;
  logic [TW-1:0] tally, tally_nxt, tally_inc;
  logic [SW-1:0] ptr, ptr_nxt;

  assign tally_inc     = tally + 1'b1;
  assign access_accept = access_valid && access_ready;
  assign halve_set     = ptr;

  // State, tally and sweep pointer registers; reset aborts any sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tally <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      tally <= tally_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next-state: the access that completes the period is still taken, the
  // sweep starts on the following cycle and lasts exactly NUM_SETS cycles.
  always_comb begin
    state_nxt    = state;
    tally_nxt    = tally;
    ptr_nxt      = ptr;
    access_ready = 1'b0;
    halve_en     = 1'b0;
    case (state)
      IDLE: begin
        access_ready = 1'b1;
        if (access_valid) begin
          if (tally_inc == TW'(AGE_PERIOD)) begin
            tally_nxt = '0;
            ptr_nxt   = '0;
            state_nxt = SWEEP;
          end else begin
            tally_nxt = tally_inc;
          end
        end
      end
      SWEEP: begin
        halve_en = 1'b1;
        if (ptr == SW'(NUM_SETS - 1)) begin
          ptr_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/lfu_counter_bank.sv
// Per-set, per-way LFU access counters with a registered query port and
// periodic halving driven by lfu_age_ctrl.
module lfu_counter_bank
  import lfu_pkg::*;
#(
  parameter int sizeCounter = SIZE_COUNTER,
  parameter int NUM_SETS    = 16,
  parameter int AGE_PERIOD  = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        access_valid,
  output logic                        access_ready,
  input  logic [$clog2(NUM_SETS)-1:0] access_set,
  input  logic [1:0]                  access_way,
  input  logic                        access_fill,
  input  logic [$clog2(NUM_SETS)-1:0] query_set,
  output logic [sizeCounter-1:0]      count0,
  output logic [sizeCounter-1:0]      count1,
  output logic [sizeCounter-1:0]      count2,
  output logic [sizeCounter-1:0]      count3,
  output logic                        count_valid
);

  localparam int SW = $clog2(NUM_SETS);

  localparam logic [sizeCounter-1:0] CNT_MAX = '1;
  localparam logic [sizeCounter-1:0] CNT_ONE = sizeCounter'(1);

  logic [NUM_SETS-1:0][WAYS-1:0][sizeCounter-1:0] cnt;
  logic [WAYS-1:0][sizeCounter-1:0]               rd_q;
  logic [sizeCounter-1:0]                         cur_val, upd_val;
  logic                                           access_accept;
  logic                                           halve_en;
  logic [SW-1:0]                                  halve_set;
  way_t                                           acc_way;

  assign acc_way = access_way;

  lfu_age_ctrl #(
    .NUM_SETS  (NUM_SETS),
    .AGE_PERIOD(AGE_PERIOD)
  ) u_age (
    .clk          (clk),
    .rst_n        (rst_n),
    .access_valid (access_valid),
    .access_ready (access_ready),
    .access_accept(access_accept),
    .halve_en     (halve_en),
    .halve_set    (halve_set)
  );

  // Updated value for the accessed counter: fill restarts at 1, hit saturates.
  always_comb begin
    cur_val = cnt[access_set][acc_way];
    upd_val = cur_val;
    if (access_fill)
      upd_val = CNT_ONE;
    else if (cur_val != CNT_MAX)
      upd_val = cur_val + 1'b1;
  end

  // Counter array; halving and access updates never overlap because the
  // bank refuses accesses while sweeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (halve_en) begin
      for (int w = 0; w < WAYS; w++)
        cnt[halve_set][w] <= cnt[halve_set][w] >> 1;
    end else if (access_accept) begin
      cnt[access_set][acc_way] <= upd_val;
    end
  end

  // Registered read port; samples the array before this edge's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q        <= '0;
      count_valid <= 1'b0;
    end else begin
      rd_q        <= cnt[query_set];
      count_valid <= 1'b1;
    end
  end

  assign count0 = rd_q[0];
  assign count1 = rd_q[1];
  assign count2 = rd_q[2];
  assign count3 = rd_q[3];

endmodule

// File: doc/lfu_counter_bank.md
Name: lfu_counter_bank

Overview:
Per-set, per-way access-frequency counter storage for the 4-way set-associative cache. Directly upstream of the LFU victim comparator.
- Records hits (increment) and fills (restart at 1) per way.
- Presents the four registered counts of a queried set as count0..count3, which drive the comparator's count inputs.
- Runs a periodic aging sweep that halves every counter so stale popularity decays.

Parameters:
sizeCounter, 4, width of each way counter (matches comparator sizeCounter)
NUM_SETS, 16, number of cache sets (power of two, >= 2)
AGE_PERIOD, 64, accepted accesses between aging sweeps (>= 2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
access_valid  in  1  access request this cycle
access_ready  out  1  bank can accept an access (low during aging sweep)
access_set  in  $clog2(NUM_SETS)  set index of access
access_way  in  2  way index of access
access_fill  in  1  1 = line fill (counter := 1), 0 = hit (counter += 1)
query_set  in  $clog2(NUM_SETS)  set whose counts are presented
count0..count3  out  sizeCounter each  registered counts of query_set, ways 0..3
count_valid  out  1  count0..3 reflect a query issued the previous cycle

Behaviour:
- Reset (async assert, sync-released use): all counters 0; count0..3 = 0; count_valid = 0; access_ready = 1; FSM = IDLE; access tally = 0. Reset mid-sweep aborts the sweep; no partial state survives.
- Access accepted iff access_valid && access_ready; the update is visible in the array on the next edge.
  - Hit: counter[set][way] += 1, saturating at 2^sizeCounter-1 (15 by default). No wrap.
  - Fill: counter[set][way] := 1. Other ways of the set are unchanged.
- Query: one-cycle latency. count_valid rises the cycle after rst_n deasserts and then stays 1, since query_set is sampled every cycle.
  - Read-before-write: a query of the set being updated in the same cycle returns the pre-update values.
- Aging FSM:
  - IDLE: each accepted access increments the tally. On the access that makes tally == AGE_PERIOD, the tally clears and the next state is SWEEP. That triggering access is committed normally.
  - SWEEP: access_ready = 0. An internal set pointer runs 0..NUM_SETS-1, one set per cycle. All four counters of the pointed set := counter >> 1.
  - After set NUM_SETS-1 is processed, return to IDLE. access_ready = 1 on the following cycle.
  - Sweep duration is exactly NUM_SETS cycles.
- Queries remain serviced during SWEEP. A queried set is read before that cycle's halving.
- access_valid held high while access_ready = 0 is simply not accepted. The requester must hold the request, and the bank takes it on the first cycle ready returns.
- Tally width: $clog2(AGE_PERIOD+1). Tally does not count during SWEEP.

Decomposition:
- Shared package lfu_pkg holds:
  - WAYS = 4
  - way index typedef (logic [1:0])
  - counter typedef parameterised by sizeCounter, via a package-level localparam default 4
  - aging FSM state enum {IDLE, SWEEP}
- One natural sub-module, lfu_age_ctrl: owns the tally, FSM, sweep pointer and access_ready, and drives the halve-enable and set index into the array.
- The counter array and read port stay in lfu_counter_bank.

Test Plan:
- Reset, then query set 3 -> count0..3 = 0 one cycle later; count_valid = 1; access_ready = 1.
- Fill set 5 way 2, then 4 hits to set 5 way 2, then query set 5 -> count2 = 5, others 0.
- 20 hits to set 1 way 0 -> count0 = 15 (saturated, no wrap to 4); ways 1..3 = 0.
- Same cycle: hit set 7 way 1 and query set 7 (prior count1 = 3) -> returned count1 = 3; next-cycle query returns 4.
- Starting from set 2 way 3 = 9 and tally 0, issue 64 accepted accesses elsewhere:
  - access_ready low for exactly 16 cycles starting the cycle after the 64th.
  - Afterwards set 2 way 3 = 4; a request held during the sweep is accepted on the first ready cycle.
- Assert rst_n low at sweep cycle 5 -> all counts 0, access_ready = 1 after release, the next sweep needs a full 64 accesses.
